base_rslice: RTL and testbench
==============================

# base_rslice

Registered valid/ready pipeline slice with a 2-entry skid buffer, used between AFU pipeline stages built from flat `base_vlat` registers. It breaks long combinational valid/ready paths in both directions. Both `o_v`/`o_d` and `i_r` come from flops, and full throughput (one transfer per cycle) is sustained. Optional parity protects the stored data.

## Interface
Parameters:
- `width`, default 8: data width in bits.

Ports:
- `clk`, input, 1: clock; all state on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `i_v`, input, 1: upstream valid.
- `i_r`, output, 1: upstream ready; registered.
- `i_d`, input, `width`: upstream data.
- `i_dp`, input, 1: upstream even-parity bit over `i_d`. Used only with `BASE_RSLICE_PAR_EN`.
- `o_v`, output, 1: downstream valid; registered.
- `o_r`, input, 1: downstream ready.
- `o_d`, output, `width`: downstream data; registered.
- `o_dp`, output, 1: parity bit accompanying `o_d`.
- `o_perr`, output, 1: parity-error pulse; registered.

## Operation
Handshake rules:
- Input transfer when `i_v & i_r`. Output transfer when `o_v & o_r`.
- When `i_r=0`, `i_d` is ignored even if `i_v=1`.
- While `o_v=1 & o_r=0`, `o_v`, `o_d` and `o_dp` hold stable.

Storage:
- Main entry: drives `o_d`/`o_dp`.
- Skid entry: holds one extra beat.
- State is derived from two valid flops: EMPTY (neither valid), ONE (main valid), FULL (both valid).

`i_r` is the registered inverse of the skid-valid flop: it is 1 in EMPTY and ONE, 0 in FULL.

Transitions, evaluated at each clock edge:
- EMPTY:
  - `i_v=1`: main ← `i_d`, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - `i_v & o_r`: main ← `i_d`, stay in ONE (pass-through at full rate).
  - `i_v & ~o_r`: skid ← `i_d`, go to FULL, `i_r` ← 0.
  - `~i_v & o_r`: go to EMPTY.
  - Otherwise hold.
- FULL (input not accepted):
  - `o_r=1`: main ← skid, go to ONE, `i_r` ← 1.
  - Otherwise hold.

Ordering:
- Beats leave in arrival order. No beat is dropped or duplicated.

Reset (asynchronous):
- Forces EMPTY immediately.
- Output values: `o_v=0`, `i_r=1`, `o_d=0`, `o_dp=0`, `o_perr=0`.
- Reset mid-operation discards both entries without a drain.
- Data flops clear to 0; a later bench compare against X is illegal.

## Timing
- Latency: a beat accepted at edge N appears on `o_v`/`o_d` after edge N, visible in cycle N+1.
- Throughput: 1 beat/cycle with `o_r` held at 1, indefinitely.
- Stall recovery: when `o_r` rises in FULL, `i_r` returns to 1 the cycle after the output transfer.
- No combinational path exists from `o_r` to `i_r`, or from `i_v`/`i_d` to `o_v`/`o_d`.
- `o_perr` is asserted the cycle after the output transfer that carried the bad beat, for exactly 1 cycle per bad beat.
- `o_perr` can assert on back-to-back cycles.

## Configuration
Macro `BASE_RSLICE_PAR_EN`.

Defined:
- Each entry stores `i_dp` alongside `i_d`, and `o_dp` = the stored bit.
- At each output transfer, if `^o_d ^ o_dp` is 1, `o_perr` pulses on the next cycle.
- Data passes through unchanged; no correction is performed.

Undefined:
- `i_dp` is unused and no parity flops exist.
- `o_dp` = `^o_d`, combinational, so it is always correct.
- `o_perr` is tied to 0.
- Handshake behaviour is identical in both builds.

## Test plan
- Reset, then idle: `o_v=0`, `i_r=1`, `o_d=0`, `o_perr=0`. Drive `i_v=1`, `i_d=0x5A` for 1 cycle: `o_v=1`, `o_d=0x5A` the next cycle.
- Stream `0x01..0x10` with `i_v=1`, `o_r=1`: 16 consecutive output beats `0x01..0x10`, one cycle later, no bubbles, `i_r` stays at 1.
- Stream `0x01..0x04` with `o_r=0` from cycle 2:
  - After 2 beats are accepted, `i_r=0` and `o_d=0x01` is held.
  - Raise `o_r`: outputs are `0x01, 0x02, 0x03, 0x04` in order.
  - `i_r` returns to 1 one cycle after the `0x01` transfer.
- Random `i_v`/`o_r` (50%) for 10k beats of incrementing data: output equals input sequence; `o_v`/`o_d` never change while stalled.
- Assert `reset` asynchronously while FULL: `o_v=0` and `i_r=1` immediately. After release, the first output is the first beat sent after reset.
- With `BASE_RSLICE_PAR_EN`, send `i_d=0x03`, `i_dp=1`, then `0x03`, `0`:
  - `o_perr` pulses exactly once, the cycle after the first beat's output transfer.
  - Without the macro, `o_perr` stays 0 and `o_dp=0` for `0x03`.

Source files
------------

// File: rtl/base_rslice.sv
// Registered valid/ready slice with a two-entry skid buffer; i_r and o_v/o_d come straight from flops.
// Define BASE_RSLICE_PAR_EN to carry and check an even-parity bit with each stored beat.
module base_rslice #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_d,
  input  logic             i_dp,
  output logic             o_v,
  input  logic             o_r,
  output logic [width-1:0] o_d,
  output logic             o_dp,
  output logic             o_perr
);

  function automatic logic parity(input logic [width-1:0] d);
    return ^d;
  endfunction

  logic             main_vld_p1;
  logic             skid_vld_p0;
  logic [width-1:0] main_d_p1;
  logic [width-1:0] skid_d_p0;
  logic             load_main;
  logic             load_skid;
  logic             pop_skid;

  // Main loads from the input when empty or when its beat leaves this cycle;
  // a beat arriving during a stall in ONE parks in the skid entry instead.
  assign load_main = i_v & ~skid_vld_p0 & (~main_vld_p1 | o_r);
  assign load_skid = i_v & main_vld_p1 & ~skid_vld_p0 & ~o_r;
  assign pop_skid  = skid_vld_p0 & o_r;

  assign i_r = ~skid_vld_p0;
  assign o_v = main_vld_p1;
  assign o_d = main_d_p1;

  // ---- stage p0 -> p1 : entry valid flops and data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p0 <= 1'b0;
      main_d_p1   <= '0;
      skid_d_p0   <= '0;
    end else begin
      main_vld_p1 <= skid_vld_p0 | (main_vld_p1 ? (i_v | ~o_r) : i_v);
      skid_vld_p0 <= skid_vld_p0 ? ~o_r : load_skid;
      if (load_main)
        main_d_p1 <= i_d;
      else if (pop_skid)
        main_d_p1 <= skid_d_p0;
      if (load_skid)
        skid_d_p0 <= i_d;
    end
  end

`ifdef BASE_RSLICE_PAR_EN
  logic main_dp_p1;
  logic skid_dp_p0;

  assign o_dp = main_dp_p1;

  // ---- stored parity follows the data path; error flagged after the bad beat leaves
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_dp_p1 <= 1'b0;
      skid_dp_p0 <= 1'b0;
      o_perr     <= 1'b0;
    end else begin
      if (load_main)
        main_dp_p1 <= i_dp;
      else if (pop_skid)
        main_dp_p1 <= skid_dp_p0;
      if (load_skid)
        skid_dp_p0 <= i_dp;
      o_perr <= main_vld_p1 & o_r & (parity(main_d_p1) ^ main_dp_p1);
    end
  end
`else
  logic unused_dp;

  assign unused_dp = i_dp;
  assign o_dp      = parity(main_d_p1);
  assign o_perr    = 1'b0;
`endif

endmodule

// File: tb/tb_base_rslice.sv
// Directed and randomized-handshake checks for base_rslice (width 8), both parity builds.
module tb_base_rslice;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_v;
  logic         i_r;
  logic [W-1:0] i_d;
  logic         i_dp;
  logic         o_v;
  logic         o_r;
  logic [W-1:0] o_d;
  logic         o_dp;
  logic         o_perr;

  int checks   = 0;
  int failures = 0;

  base_rslice #(.width(W)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_dp(i_dp),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_dp(o_dp), .o_perr(o_perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    i_v  = v;
    i_d  = d;
    i_dp = ^d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] nxt;
    logic [W-1:0] exp_d;
    logic         prev_v;
    logic         prev_r;
    logic [W-1:0] prev_d;
    int           sent;
    int           cyc;

    reset = 1'b1;
    drive(1'b0, 8'h00);
    o_r = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset / idle state
    chk("rst_o_v", o_v, 0);
    chk("rst_i_r", i_r, 1);
    chk("rst_o_d", o_d, 0);
    chk("rst_o_dp", o_dp, 0);
    chk("rst_o_perr", o_perr, 0);

    // Single beat
    drive(1'b1, 8'h5A);
    tick();
    drive(1'b0, 8'h00);
    chk("one_o_v", o_v, 1);
    chk("one_o_d", o_d, 8'h5A);
    chk("one_i_r", i_r, 1);
    o_r = 1'b1;
    tick();
    chk("one_drain", o_v, 0);

    // Full-rate stream 0x01..0x10
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, W'(k));
      tick();
      chk("stream_o_v", o_v, 1);
      chk("stream_o_d", o_d, k);
      chk("stream_i_r", i_r, 1);
    end
    drive(1'b0, 8'h00);
    tick();
    chk("stream_end", o_v, 0);

    // Stall fills the skid entry, then drains in order
    o_r = 1'b0;
    drive(1'b1, 8'h01);
    tick();
    chk("stall_d1", o_d, 8'h01);
    chk("stall_ir1", i_r, 1);
    drive(1'b1, 8'h02);
    tick();
    chk("stall_full_ir", i_r, 0);
    chk("stall_full_d", o_d, 8'h01);
    drive(1'b1, 8'h03);
    tick();
    chk("stall_hold_ir", i_r, 0);
    chk("stall_hold_v", o_v, 1);
    chk("stall_hold_d", o_d, 8'h01);
    o_r = 1'b1;
    tick();
    chk("drain_d2", o_d, 8'h02);
    chk("drain_ir", i_r, 1);
    tick();
    chk("drain_d3", o_d, 8'h03);
    drive(1'b1, 8'h04);
    tick();
    chk("drain_d4", o_d, 8'h04);
    drive(1'b0, 8'h00);
    tick();
    chk("drain_empty", o_v, 0);

    // Random handshakes, 10k beats
    nxt  = '0;
    sent = 0;
    cyc  = 0;
    q.delete();
    while (sent < 10000 && cyc < 60000) begin
      drive(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, nxt);
      o_r = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      if (o_v && o_r) begin
        if (q.size() == 0)
          chk("rand_spurious", 1, 0);
        else begin
          exp_d = q.pop_front();
          chk("rand_data", o_d, exp_d);
        end
      end
      if (i_v && i_r) begin
        q.push_back(nxt);
        nxt++;
        sent++;
      end
      prev_v = o_v;
      prev_r = o_r;
      prev_d = o_d;
      tick();
      cyc++;
      if (prev_v && !prev_r)
        chk("rand_stall_hold", {o_v, o_d}, {1'b1, prev_d});
    end
    chk("rand_send_budget", (sent >= 10000) ? 1 : 0, 1);
    drive(1'b0, 8'h00);
    o_r = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      if (o_v) begin
        exp_d = q.pop_front();
        chk("rand_drain", o_d, exp_d);
      end
      tick();
      cyc++;
    end
    chk("rand_drain_done", q.size(), 0);
    chk("rand_drain_empty", o_v, 0);
    chk("rand_perr", o_perr, 0);

    // Asynchronous reset while FULL
    o_r = 1'b0;
    drive(1'b1, 8'hA1);
    tick();
    drive(1'b1, 8'hA2);
    tick();
    chk("arst_full_ir", i_r, 0);
    drive(1'b0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_o_v", o_v, 0);
    chk("arst_i_r", i_r, 1);
    chk("arst_o_d", o_d, 0);
    tick();
    #3;
    reset = 1'b0;
    tick();
    drive(1'b1, 8'hB7);
    tick();
    drive(1'b0, 8'h00);
    chk("arst_first_v", o_v, 1);
    chk("arst_first_d", o_d, 8'hB7);
    o_r = 1'b1;
    tick();
    chk("arst_no_stale", o_v, 0);

    // Parity: bad beat then good beat of 0x03
    i_v = 1'b1; i_d = 8'h03; i_dp = 1'b1;
    tick();
    chk("par_perr0", o_perr, 0);
`ifdef BASE_RSLICE_PAR_EN
    chk("par_dp_bad", o_dp, 1);
`else
    chk("par_dp_bad", o_dp, 0);
`endif
    i_v = 1'b1; i_d = 8'h03; i_dp = 1'b0;
    tick();
    drive(1'b0, 8'h00);
`ifdef BASE_RSLICE_PAR_EN
    chk("par_perr_pulse", o_perr, 1);
`else
    chk("par_perr_pulse", o_perr, 0);
`endif
    chk("par_dp_good", o_dp, 0);
    chk("par_d_good", o_d, 8'h03);
    tick();
    chk("par_perr_clear", o_perr, 0);
    chk("par_empty", o_v, 0);
    tick();
    chk("par_perr_idle", o_perr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
